// File: rtl/vector_pkg.sv
// Shared constants and helpers for the vector datapath blocks.
// Holds the pipeline depth, the product width and the lane slice offsets.
package vector_pkg;

    localparam int PIPE_DEPTH = 2;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int op_lo(input int i, input int w);
        return i * w;
    endfunction

    function automatic int prod_lo(input int i, input int w);
        return i * prod_w(w);
    endfunction

endpackage

// File: rtl/mult_lane.sv
// One multiplier lane: the full-width product register for stage S2.
// Ports: Clock, Reset_n, load (capture a*b), a, b (W_u each), p (2*W_u).
// VECTOR_MULT_SIGNED_EN selects a two's-complement product.
module mult_lane
    import vector_pkg::*;
#(
    parameter int W_u = 8
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     load,
    input  logic [W_u-1:0]           a,
    input  logic [W_u-1:0]           b,
    output logic [prod_w(W_u)-1:0]   p
);

    localparam int PW = prod_w(W_u);

    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    logic [PW-1:0] prod;

    // Extending to the product width first keeps the low 2*W_u bits exact.
`ifdef VECTOR_MULT_SIGNED_EN
    assign ax = {{W_u{a[W_u-1]}}, a};
    assign bx = {{W_u{b[W_u-1]}}, b};
`else
    assign ax = {{W_u{1'b0}}, a};
    assign bx = {{W_u{1'b0}}, b};
`endif

    assign prod = ax * bx;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            p <= '0;
        end else if (load) begin
            p <= prod;
        end
    end

endmodule

// File: rtl/vector_mult.sv
// Two-stage element-wise vector multiplier with valid/ready handshakes.
// Ports: Clock, Reset_n, inValid/inReady/u/v in, outValid/outReady/p out,
// inFlight = pairs held. VECTOR_MULT_SIGNED_EN selects signed elements.
module vector_mult
    import vector_pkg::*;
#(
    parameter int DIM = 2,
    parameter int W_u = 8
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [DIM*W_u-1:0]     u,
    input  logic [DIM*W_u-1:0]     v,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DIM*2*W_u-1:0]   p,
    output logic [1:0]             inFlight
);

    localparam int PW = prod_w(W_u);

    logic                 s1_valid;
    logic                 s2_valid;
    logic [DIM*W_u-1:0]   s1_u;
    logic [DIM*W_u-1:0]   s1_v;
    logic [DIM*PW-1:0]    prod;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 s2_load;

    // Depends only on stage state and outReady, never on inValid.
    assign inReady  = !s1_valid || !s2_valid || outReady;
    assign in_xfer  = inValid && inReady;
    assign out_xfer = s2_valid && outReady;
    assign s2_load  = s1_valid && (!s2_valid || outReady);

    assign outValid = s2_valid;
    assign p        = s2_valid ? prod : '0;

    // S1 can take new data whenever inReady is high (empty or draining).
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_u     <= '0;
            s1_v     <= '0;
        end else if (inReady) begin
            s1_valid <= inValid;
            if (inValid) begin
                s1_u <= u;
                s1_v <= v;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            inFlight <= 2'd0;
        end else begin
            unique case ({in_xfer, out_xfer})
                2'b10:   inFlight <= inFlight + 2'd1;
                2'b01:   inFlight <= inFlight - 2'd1;
                default: inFlight <= inFlight;
            endcase
        end
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        mult_lane #(
            .W_u(W_u)
        ) u_lane (
            .Clock   (Clock),
            .Reset_n (Reset_n),
            .load    (s2_load),
            .a       (s1_u[op_lo(i, W_u) +: W_u]),
            .b       (s1_v[op_lo(i, W_u) +: W_u]),
            .p       (prod[prod_lo(i, W_u) +: PW])
        );
    end

endmodule

// File: tb/tb_vector_mult.sv
// Self-checking bench for vector_mult (DIM=2, W_u=8).
// Table vectors plus hand sequences, checked through a scoreboard queue.
module tb_vector_mult;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] u = '0;
    logic [15:0] v = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [31:0] p;
    logic [1:0]  inFlight;

    int checks = 0;
    int fails = 0;
    logic [31:0] sb[$];
    bit rnd_en = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t tab[4];

    vector_mult #(
        .DIM(2),
        .W_u(8)
    ) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .inValid  (inValid),
        .inReady  (inReady),
        .u        (u),
        .v        (v),
        .outValid (outValid),
        .outReady (outReady),
        .p        (p),
        .inFlight (inFlight)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        logic [31:0] r;
        int x;
        int y;
        r = '0;
        for (int i = 0; i < 2; i++) begin
`ifdef VECTOR_MULT_SIGNED_EN
            x = int'($signed(a[i*8 +: 8]));
            y = int'($signed(b[i*8 +: 8]));
`else
            x = int'(a[i*8 +: 8]);
            y = int'(b[i*8 +: 8]);
`endif
            r[i*16 +: 16] = 16'(x * y);
        end
        return r;
    endfunction

    // Monitor: looks at the transfer about to happen on the next rising edge.
    always @(negedge Clock) begin
        if (Reset_n) begin
            check("inflight", 64'(inFlight), 64'(sb.size()));
            if (!outValid) begin
                check("p_idle_zero", 64'(p), 64'd0);
            end else if (outReady) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_out: got %0h, expected none", p);
                end else begin
                    check("p_out", 64'(p), 64'(sb.pop_front()));
                end
            end
        end
    end

    always @(posedge Clock) begin
        if (rnd_en) begin
            #1 outReady = 1'($urandom_range(0, 1));
        end
    end

    // One cycle of driving; called at posedge+1, returns at posedge+1.
    task automatic step(input bit val, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] e,
                        output bit acc);
        inValid = val;
        u = a;
        v = b;
        @(negedge Clock);
        acc = val && inReady;
        @(posedge Clock);
        if (acc) sb.push_back(e);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] e);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            step(1'b1, a, b, e, acc);
        end
        if (!acc) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got no accept, expected accept");
        end
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, '0, acc);
    endtask

    initial begin
        bit acc;
        logic [31:0] hold;
        logic [15:0] ra;
        logic [15:0] rb;

        tab[0] = '{16'h0307, 16'h0209, 32'h0006_003F};
        tab[1] = '{16'h640A, 16'h010C, 32'h0064_0078};
        tab[2] = '{16'h7F00, 16'h7F05, 32'h3F01_0000};
        tab[3] = '{16'h0B0C, 16'h0D0E, 32'h008F_00A8};

        // Reset state
        repeat (2) @(posedge Clock);
        #1;
        check("rst_outValid", 64'(outValid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_inFlight", 64'(inFlight), 64'd0);
        check("rst_inReady", 64'(inReady), 64'd1);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        check("post_rst_outValid", 64'(outValid), 64'd0);
        check("post_rst_inReady", 64'(inReady), 64'd1);

        // Single pair: latency 2, outValid for exactly one cycle
        outReady = 1'b1;
        step(1'b1, 16'h0801, 16'h0503, 32'h0028_0003, acc);
        check("lat_accept", 64'(acc), 64'd1);
        check("lat_cyc1_outValid", 64'(outValid), 64'd0);
        step(1'b0, '0, '0, '0, acc);
        check("lat_cyc2_outValid", 64'(outValid), 64'd1);
        check("lat_cyc2_p", 64'(p), 64'h0028_0003);
        step(1'b0, '0, '0, '0, acc);
        check("lat_cyc3_outValid", 64'(outValid), 64'd0);

        // Back-to-back table vectors
        for (int i = 0; i < 4; i++) begin
            step(1'b1, tab[i].a, tab[i].b, tab[i].e, acc);
            check("b2b_inReady", 64'(acc), 64'd1);
        end
        idle(3);

        // Backpressure: third pair refused, output stable, then drain
        outReady = 1'b0;
        step(1'b1, 16'h0102, 16'h0304, 32'h0003_0008, acc);
        check("bp_acc0", 64'(acc), 64'd1);
        step(1'b1, 16'h0506, 16'h0708, 32'h0023_0030, acc);
        check("bp_acc1", 64'(acc), 64'd1);
        hold = p;
        check("bp_head_p", 64'(hold), 64'h0003_0008);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'h090A, 16'h0B0C, 32'h0063_0078, acc);
            check("bp_refused", 64'(acc), 64'd0);
            check("bp_inReady", 64'(inReady), 64'd0);
            check("bp_inFlight", 64'(inFlight), 64'd2);
            check("bp_p_stable", 64'(p), 64'(hold));
            check("bp_outValid", 64'(outValid), 64'd1);
        end
        outReady = 1'b1;
        send(16'h090A, 16'h0B0C, 32'h0063_0078);
        idle(4);

        // Lane extremes
`ifdef VECTOR_MULT_SIGNED_EN
        send(16'h0080, 16'h00FF, 32'h0000_0080);
        step(1'b0, '0, '0, '0, acc);
        check("ext_lane0", 64'(p), 64'h0000_0080);
        send(16'h8080, 16'h8080, 32'h4000_4000);
`else
        send(16'h00FF, 16'h00FF, 32'h0000_FE01);
        step(1'b0, '0, '0, '0, acc);
        check("ext_lane0", 64'(p), 64'h0000_FE01);
        send(16'hFFFF, 16'hFFFF, 32'hFE01_FE01);
`endif
        idle(3);

        // Random pairs under random backpressure
        rnd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, model(ra, rb));
        end
        rnd_en = 1'b0;
        @(posedge Clock);
        #2;
        outReady = 1'b1;
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
        check("drain_empty", 64'(sb.size()), 64'd0);

        // Reset while two pairs are held
        outReady = 1'b0;
        send(16'h0203, 16'h0405, 32'h0008_000F);
        send(16'h0607, 16'h0809, 32'h0030_003F);
        check("mr_inFlight_full", 64'(inFlight), 64'd2);
        Reset_n = 1'b0;
        sb.delete();
        #1;
        check("mr_outValid", 64'(outValid), 64'd0);
        check("mr_p", 64'(p), 64'd0);
        check("mr_inFlight", 64'(inFlight), 64'd0);
        check("mr_inReady", 64'(inReady), 64'd1);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        outReady = 1'b1;
        step(1'b1, 16'h0A03, 16'h0C07, 32'h0078_0015, acc);
        check("mr_accept", 64'(acc), 64'd1);
        check("mr_cyc1_outValid", 64'(outValid), 64'd0);
        step(1'b0, '0, '0, '0, acc);
        check("mr_cyc2_outValid", 64'(outValid), 64'd1);
        check("mr_cyc2_p", 64'(p), 64'h0078_0015);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/vector_mult.md
VECTOR_MULT -- requirements
Module: vector_mult

Interface
REQ-001 Parameter DIM, default 2, number of vector elements (lanes); legal range 1..64.
REQ-002 Parameter W_u, default 8, bit-width of each input element; legal range 2..32.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 inValid  input  1  upstream asserts when u and v carry a valid operand pair.
REQ-006 inReady  output  1  block can accept an operand pair this cycle.
REQ-007 u  input  DIM*W_u  operand vector A; element i occupies bits [i*W_u +: W_u].
REQ-008 v  input  DIM*W_u  operand vector B; same element packing as u.
REQ-009 outValid  output  1  p holds a valid product vector.
REQ-010 outReady  input  1  downstream (vectorSum feed) accepts p this cycle.
REQ-011 p  output  DIM*2*W_u  product vector; lane i at bits [i*2*W_u +: 2*W_u], p[i] = u[i]*v[i].
REQ-012 inFlight  output  2  count of operand pairs held in the pipeline (0..2).

Function
REQ-013 An input transfer occurs on a rising edge with inValid && inReady; an output transfer occurs with outValid && outReady.
REQ-014 Two-stage pipeline: S1 registers u, v and a valid bit; S2 registers DIM full-width products and a valid bit.
REQ-015 Latency: an accepted pair appears on p with outValid=1 exactly 2 cycles after its input transfer when S2 is free.
REQ-016 Throughput: one pair per cycle while outReady=1 continuously; no bubbles inserted.
REQ-017 S2 loads from S1 when S1 is valid and (S2 is empty or an output transfer occurs in the same cycle).
REQ-018 S1 loads from the inputs when (S1 is empty or S1 advances into S2 in the same cycle).
REQ-019 inReady = !S1valid || !S2valid || outReady (combinational; no combinational path from inValid to inReady).
REQ-020 While outValid=1 and outReady=0, p and outValid hold their values unchanged.
REQ-021 Full pipeline (both stages valid) with outReady=0: inReady=0, and the input data is ignored regardless of inValid.
REQ-022 Simultaneous input and output transfers in one cycle leave inFlight unchanged; input-only increments it, output-only decrements it.
REQ-023 The product width is exactly 2*W_u per lane; no truncation, rounding, or saturation.
REQ-024 Data in an empty stage is don't-care internally, but p is driven to 0 whenever outValid=0.

Reset
REQ-025 Reset_n low asynchronously clears S1valid, S2valid, and inFlight, and all S1/S2 data registers, to 0.
REQ-026 During and directly after reset: outValid=0, p=0, inFlight=0, and inReady=1.
REQ-027 Reset asserted mid-operation discards all in-flight pairs; no partial result is ever presented after reset.

Configuration
REQ-028 Macro VECTOR_MULT_SIGNED_EN defined: elements are two's-complement and the products are signed and sign-extended to 2*W_u.
REQ-029 Macro VECTOR_MULT_SIGNED_EN undefined: elements and products are unsigned; all other behaviour is identical.

Structure
REQ-030 Shared package vector_pkg holds the pipeline-depth constant (2), the product-width function (2*W_u), and the lane slice-index helpers; vectorSum uses the same package.
REQ-031 One sub-module, mult_lane, holds the S2 product register and multiply for one lane; it is instantiated DIM times through a generate loop.
REQ-032 Valid/ready control and the inFlight counter reside in vector_mult only, not in mult_lane.

Verification
REQ-033 DIM=2, W_u=8, outReady=1; u={8,1}, v={5,3} (lane1,lane0), one input transfer -> 2 cycles later p={40,3} and outValid=1 for exactly 1 cycle.
REQ-034 Back-to-back inputs on 4 consecutive cycles with outReady=1 -> 4 consecutive outputs in order, with inReady=1 throughout.
REQ-035 outReady=0 while 3 pairs are offered -> 2 pairs are accepted, inReady=0, inFlight=2, and p stays stable; raise outReady -> outputs drain in order.
REQ-036 Unsigned build, lane0 u=255, v=255 -> p lane0=65025; signed build, u=8'h80, v=8'hFF -> p lane0=16'h0080 (+128).
REQ-037 Assert Reset_n low for 1 cycle while inFlight=2 -> outValid=0, p=0, inFlight=0 immediately; the next input's result appears after 2 cycles with correct values.
